rvh_l1d_bank_axi_mux: RTL and testbench

- Parametrised N-bank to 1 AXI master multiplexer between the L1D banks and L2.
- Independent round-robin arbitration on AR and AW, with grants held stable while stalled.
- W beats are routed in AW-grant order through a write-order FIFO.
- Per-bank outstanding read/write limits; R and B are routed back by the bank-index field in the ID.

---
 rtl/rvh_l1d_bank_axi_mux.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_rvh_l1d_bank_axi_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_bank_axi_mux.sv
// N-bank to single AXI master mux: round-robin AR/AW, W ordered by AW grants, R/B routed by ID bank index.
// Optional stall counters are enabled with `define RVH_L1D_AXI_MUX_PERF_CNT_EN.
module rvh_l1d_bank_axi_mux #(
    parameter int N_PORT     = 2,
    parameter int IDXW       = (N_PORT > 1) ? $clog2(N_PORT) : 1,
    parameter int AR_W       = 77,
    parameter int W_W        = 73,
    parameter int B_W        = 10,
    parameter int R_W        = 78,
    parameter int WLAST_BIT  = 8,
    parameter int RLAST_BIT  = 0,
    parameter int RID_LSB    = 74,
    parameter int BID_LSB    = 6,
    parameter int MAX_OUTST  = 4,
    parameter int WORD_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORT-1:0]        bank_arvalid,
    output logic [N_PORT-1:0]        bank_arready,
    input  logic [N_PORT*AR_W-1:0]   bank_ar,
    input  logic [N_PORT-1:0]        bank_awvalid,
    output logic [N_PORT-1:0]        bank_awready,
    input  logic [N_PORT*AR_W-1:0]   bank_aw,
    input  logic [N_PORT-1:0]        bank_wvalid,
    output logic [N_PORT-1:0]        bank_wready,
    input  logic [N_PORT*W_W-1:0]    bank_w,
    output logic [N_PORT-1:0]        bank_bvalid,
    input  logic [N_PORT-1:0]        bank_bready,
    output logic [N_PORT*B_W-1:0]    bank_b,
    output logic [N_PORT-1:0]        bank_rvalid,
    input  logic [N_PORT-1:0]        bank_rready,
    output logic [N_PORT*R_W-1:0]    bank_r,
    output logic                     l2_arvalid,
    input  logic                     l2_arready,
    output logic [AR_W-1:0]          l2_ar,
    output logic                     l2_awvalid,
    input  logic                     l2_awready,
    output logic [AR_W-1:0]          l2_aw,
    output logic                     l2_wvalid,
    input  logic                     l2_wready,
    output logic [W_W-1:0]           l2_w,
    input  logic                     l2_bvalid,
    output logic                     l2_bready,
    input  logic [B_W-1:0]           l2_b,
    input  logic                     l2_rvalid,
    output logic                     l2_rready,
    input  logic [R_W-1:0]           l2_r,
    output logic                     resp_err
`ifdef RVH_L1D_AXI_MUX_PERF_CNT_EN
    ,
    output logic [31:0]              perf_ar_stall,
    output logic [31:0]              perf_aw_stall
`endif
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTST);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(WORD_DEPTH);
    localparam logic [IDXW:0]   NPORT_C = (IDXW+1)'(N_PORT);

    // Lowest offset from ptr among eligible ports wins.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N_PORT-1:0] elig,
                                                 input logic [IDXW-1:0]   ptr);
        logic [IDXW-1:0] sel;
        int idx;
        sel = ptr;
        for (int o = N_PORT - 1; o >= 0; o--) begin
            idx = (int'(ptr) + o) % N_PORT;
            if (elig[idx]) begin
                sel = IDXW'(idx);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] win);
        return IDXW'((int'(win) + 1) % N_PORT);
    endfunction

    // Simultaneous inc/dec cancel; a decrement at zero holds the count.
    function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c,
                                              input logic inc, input logic dec);
        logic [CW-1:0] n;
        if (inc && !dec) begin
            n = c + CW'(1);
        end else if (dec && !inc && (c != '0)) begin
            n = c - CW'(1);
        end else begin
            n = c;
        end
        return n;
    endfunction

    logic [IDXW-1:0] r_ar_ptr, r_ar_lock_idx, r_aw_ptr, r_aw_lock_idx;
    logic            r_ar_lock, r_aw_lock;
    logic [CW-1:0]   r_rd_cnt [N_PORT];
    logic [CW-1:0]   r_wr_cnt [N_PORT];
    logic [IDXW-1:0] r_wo_mem [WORD_DEPTH];
    logic [PW-1:0]   r_wo_rd, r_wo_wr;
    logic [PW:0]     r_wo_cnt;
    logic            r_resp_err;

    logic [N_PORT-1:0] w_ar_elig, w_aw_elig;
    logic [IDXW-1:0]   w_ar_sel, w_aw_sel, w_wo_head, w_r_idx, w_b_idx;
    logic              w_ar_found, w_aw_found, w_ar_hs, w_aw_hs;
    logic              w_wo_empty, w_wo_full, w_w_pop;
    logic              w_r_inr, w_b_inr, w_r_hs, w_b_hs;
    logic [N_PORT-1:0] w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec;

    assign w_wo_empty = (r_wo_cnt == '0);
    assign w_wo_full  = (r_wo_cnt == DEPTH_C);
    assign w_wo_head  = r_wo_mem[r_wo_rd];

    // AR arbitration: locked grant while stalled, otherwise round-robin over eligible ports.
    always_comb begin
        w_ar_elig    = '0;
        l2_arvalid   = 1'b0;
        l2_ar        = '0;
        bank_arready = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_ar_elig[i] = bank_arvalid[i] && (r_rd_cnt[i] < MAX_C);
        end
        if (r_ar_lock) begin
            w_ar_sel   = r_ar_lock_idx;
            w_ar_found = 1'b1;
        end else begin
            w_ar_sel   = rr_pick(w_ar_elig, r_ar_ptr);
            w_ar_found = |w_ar_elig;
        end
        for (int i = 0; i < N_PORT; i++) begin
            if (w_ar_sel == IDXW'(i)) begin
                l2_arvalid      = w_ar_found && bank_arvalid[i];
                l2_ar           = bank_ar[i*AR_W +: AR_W];
                bank_arready[i] = w_ar_found && bank_arvalid[i] && l2_arready;
            end else begin
                bank_arready[i] = 1'b0;
            end
        end
    end

    // AW arbitration: as AR, additionally blocked while the write-order FIFO is full.
    always_comb begin
        w_aw_elig    = '0;
        l2_awvalid   = 1'b0;
        l2_aw        = '0;
        bank_awready = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_aw_elig[i] = bank_awvalid[i] && (r_wr_cnt[i] < MAX_C);
        end
        if (r_aw_lock) begin
            w_aw_sel   = r_aw_lock_idx;
            w_aw_found = !w_wo_full;
        end else begin
            w_aw_sel   = rr_pick(w_aw_elig, r_aw_ptr);
            w_aw_found = (|w_aw_elig) && !w_wo_full;
        end
        for (int i = 0; i < N_PORT; i++) begin
            if (w_aw_sel == IDXW'(i)) begin
                l2_awvalid      = w_aw_found && bank_awvalid[i];
                l2_aw           = bank_aw[i*AR_W +: AR_W];
                bank_awready[i] = w_aw_found && bank_awvalid[i] && l2_awready;
            end else begin
                bank_awready[i] = 1'b0;
            end
        end
    end

    assign w_ar_hs = l2_arvalid && l2_arready;
    assign w_aw_hs = l2_awvalid && l2_awready;

    // W steering from the FIFO head; no bypass from a same-cycle AW.
    always_comb begin
        l2_wvalid   = 1'b0;
        l2_w        = '0;
        bank_wready = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (!w_wo_empty && (w_wo_head == IDXW'(i))) begin
                l2_wvalid      = bank_wvalid[i];
                l2_w           = bank_w[i*W_W +: W_W];
                bank_wready[i] = l2_wready;
            end else begin
                bank_wready[i] = 1'b0;
            end
        end
    end

    assign w_w_pop = l2_wvalid && l2_wready && l2_w[WLAST_BIT];

    assign w_r_idx = l2_r[RID_LSB +: IDXW];
    assign w_b_idx = l2_b[BID_LSB +: IDXW];
    assign w_r_inr = ({1'b0, w_r_idx} < NPORT_C);
    assign w_b_inr = ({1'b0, w_b_idx} < NPORT_C);
    assign bank_r  = {N_PORT{l2_r}};
    assign bank_b  = {N_PORT{l2_b}};

    // Response routing by ID bank index; out-of-range beats are sunk.
    always_comb begin
        bank_rvalid = '0;
        bank_bvalid = '0;
        l2_rready   = !w_r_inr;
        l2_bready   = !w_b_inr;
        for (int i = 0; i < N_PORT; i++) begin
            if (w_r_inr && (w_r_idx == IDXW'(i))) begin
                bank_rvalid[i] = l2_rvalid;
                l2_rready      = bank_rready[i];
            end else begin
                bank_rvalid[i] = 1'b0;
            end
            if (w_b_inr && (w_b_idx == IDXW'(i))) begin
                bank_bvalid[i] = l2_bvalid;
                l2_bready      = bank_bready[i];
            end else begin
                bank_bvalid[i] = 1'b0;
            end
        end
    end

    assign w_r_hs = l2_rvalid && l2_rready;
    assign w_b_hs = l2_bvalid && l2_bready;

    // Per-port outstanding counter events.
    always_comb begin
        w_rd_inc = '0;
        w_rd_dec = '0;
        w_wr_inc = '0;
        w_wr_dec = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_rd_inc[i] = w_ar_hs && (w_ar_sel == IDXW'(i));
            w_wr_inc[i] = w_aw_hs && (w_aw_sel == IDXW'(i));
            w_rd_dec[i] = w_r_hs && w_r_inr && (w_r_idx == IDXW'(i)) && l2_r[RLAST_BIT];
            w_wr_dec[i] = w_b_hs && w_b_inr && (w_b_idx == IDXW'(i));
        end
    end

    // Arbitration pointers and grant locks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar_ptr      <= '0;
            r_ar_lock     <= 1'b0;
            r_ar_lock_idx <= '0;
            r_aw_ptr      <= '0;
            r_aw_lock     <= 1'b0;
            r_aw_lock_idx <= '0;
        end else begin
            r_ar_lock     <= l2_arvalid && !l2_arready;
            r_ar_lock_idx <= w_ar_sel;
            r_aw_lock     <= l2_awvalid && !l2_awready;
            r_aw_lock_idx <= w_aw_sel;
            r_ar_ptr      <= w_ar_hs ? rr_next(w_ar_sel) : r_ar_ptr;
            r_aw_ptr      <= w_aw_hs ? rr_next(w_aw_sel) : r_aw_ptr;
        end
    end

    // Outstanding counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PORT; i++) begin
                r_rd_cnt[i] <= '0;
                r_wr_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORT; i++) begin
                r_rd_cnt[i] <= cnt_upd(r_rd_cnt[i], w_rd_inc[i], w_rd_dec[i]);
                r_wr_cnt[i] <= cnt_upd(r_wr_cnt[i], w_wr_inc[i], w_wr_dec[i]);
            end
        end
    end

    // Write-order FIFO holding the AW winner of each outstanding burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                r_wo_mem[i] <= '0;
            end
            r_wo_rd  <= '0;
            r_wo_wr  <= '0;
            r_wo_cnt <= '0;
        end else begin
            if (w_aw_hs) begin
                r_wo_mem[r_wo_wr] <= w_aw_sel;
                r_wo_wr           <= r_wo_wr + PW'(1);
            end else begin
                r_wo_wr <= r_wo_wr;
            end
            r_wo_rd <= w_w_pop ? (r_wo_rd + PW'(1)) : r_wo_rd;
            case ({w_aw_hs, w_w_pop})
                2'b10:   r_wo_cnt <= r_wo_cnt + (PW+1)'(1);
                2'b01:   r_wo_cnt <= r_wo_cnt - (PW+1)'(1);
                default: r_wo_cnt <= r_wo_cnt;
            endcase
        end
    end

    // Pulse one cycle after an out-of-range R or B beat is sunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_err <= 1'b0;
        end else begin
            r_resp_err <= (w_r_hs && !w_r_inr) || (w_b_hs && !w_b_inr);
        end
    end

    assign resp_err = r_resp_err;

    // A response with nothing outstanding is a protocol violation upstream.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_PORT; i++) begin
                assert (!(w_rd_dec[i] && (r_rd_cnt[i] == '0)))
                    else $error("rd_cnt underflow on port %0d", i);
                assert (!(w_wr_dec[i] && (r_wr_cnt[i] == '0)))
                    else $error("wr_cnt underflow on port %0d", i);
            end
        end
    end

`ifdef RVH_L1D_AXI_MUX_PERF_CNT_EN
    logic [31:0] r_perf_ar, r_perf_aw;

    // Saturating stall counters: some bank is requesting but the channel does not handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_ar <= 32'd0;
            r_perf_aw <= 32'd0;
        end else begin
            if ((|bank_arvalid) && !w_ar_hs && (r_perf_ar != 32'hFFFF_FFFF)) begin
                r_perf_ar <= r_perf_ar + 32'd1;
            end else begin
                r_perf_ar <= r_perf_ar;
            end
            if ((|bank_awvalid) && !w_aw_hs && (r_perf_aw != 32'hFFFF_FFFF)) begin
                r_perf_aw <= r_perf_aw + 32'd1;
            end else begin
                r_perf_aw <= r_perf_aw;
            end
        end
    end

    assign perf_ar_stall = r_perf_ar;
    assign perf_aw_stall = r_perf_aw;
`endif

endmodule

// File: tb/tb_rvh_l1d_bank_axi_mux.sv
// Directed self-checking bench for rvh_l1d_bank_axi_mux with two ports and a 2-bit bank-index field.
module tb_rvh_l1d_bank_axi_mux;

    localparam int N    = 2;
    localparam int IW   = 2;
    localparam int ARW  = 77;
    localparam int WW   = 73;
    localparam int BW   = 10;
    localparam int RW   = 78;

    localparam logic [ARW-1:0] AR0 = 77'h0A5;
    localparam logic [ARW-1:0] AR1 = 77'h15A;
    localparam logic [ARW-1:0] AW0 = 77'h2C3;
    localparam logic [ARW-1:0] AW1 = 77'h3D4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]     bank_arvalid, bank_arready, bank_awvalid, bank_awready;
    logic [N-1:0]     bank_wvalid, bank_wready, bank_bvalid, bank_bready;
    logic [N-1:0]     bank_rvalid, bank_rready;
    logic [N*ARW-1:0] bank_ar, bank_aw;
    logic [N*WW-1:0]  bank_w;
    logic [N*BW-1:0]  bank_b;
    logic [N*RW-1:0]  bank_r;
    logic             l2_arvalid, l2_arready, l2_awvalid, l2_awready;
    logic             l2_wvalid, l2_wready, l2_bvalid, l2_bready, l2_rvalid, l2_rready;
    logic [ARW-1:0]   l2_ar, l2_aw;
    logic [WW-1:0]    l2_w;
    logic [BW-1:0]    l2_b;
    logic [RW-1:0]    l2_r;
    logic             resp_err;
    logic [WW-1:0]    w0v, w1v;

    int checks   = 0;
    int failures = 0;

    assign bank_ar = {AR1, AR0};
    assign bank_aw = {AW1, AW0};
    assign bank_w  = {w1v, w0v};

    always #5 clk = ~clk;

    rvh_l1d_bank_axi_mux #(.N_PORT(N), .IDXW(IW)) dut (
        .clk(clk), .rst(rst),
        .bank_arvalid(bank_arvalid), .bank_arready(bank_arready), .bank_ar(bank_ar),
        .bank_awvalid(bank_awvalid), .bank_awready(bank_awready), .bank_aw(bank_aw),
        .bank_wvalid(bank_wvalid), .bank_wready(bank_wready), .bank_w(bank_w),
        .bank_bvalid(bank_bvalid), .bank_bready(bank_bready), .bank_b(bank_b),
        .bank_rvalid(bank_rvalid), .bank_rready(bank_rready), .bank_r(bank_r),
        .l2_arvalid(l2_arvalid), .l2_arready(l2_arready), .l2_ar(l2_ar),
        .l2_awvalid(l2_awvalid), .l2_awready(l2_awready), .l2_aw(l2_aw),
        .l2_wvalid(l2_wvalid), .l2_wready(l2_wready), .l2_w(l2_w),
        .l2_bvalid(l2_bvalid), .l2_bready(l2_bready), .l2_b(l2_b),
        .l2_rvalid(l2_rvalid), .l2_rready(l2_rready), .l2_r(l2_r),
        .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bank_arvalid = '0; bank_awvalid = '0; bank_wvalid = '0;
        bank_bready  = '0; bank_rready  = '0;
        l2_arready = 1'b0; l2_awready = 1'b0; l2_wready = 1'b0;
        l2_bvalid  = 1'b0; l2_rvalid  = 1'b0;
        l2_b = '0; l2_r = '0; w0v = '0; w1v = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        #2;
        chk("rst_arvalid", l2_arvalid, 1'b0);
        chk("rst_awvalid", l2_awvalid, 1'b0);
        chk("rst_wvalid", l2_wvalid, 1'b0);
        chk("rst_rready", l2_rready, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        step();
        rst = 1'b0;
        #1;

        // Round-robin alternation with both ports requesting.
        bank_arvalid = 2'b11; l2_arready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_arready", bank_arready, (g % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_payload", l2_ar, (g % 2 == 0) ? AR0 : AR1);
            step();
        end

        // Grant lock while L2 stalls.
        do_reset();
        bank_arvalid = 2'b01; l2_arready = 1'b1;
        #1; chk("lock_pre_hs", bank_arready, 2'b01);
        step();
        l2_arready = 1'b0;
        #1; chk("lock_c1_valid", l2_arvalid, 1'b1);
        chk("lock_c1_ar", l2_ar, AR0);
        step();
        bank_arvalid = 2'b11;
        #1; chk("lock_c2_ar", l2_ar, AR0);
        chk("lock_c2_ready", bank_arready, 2'b00);
        step();
        #1; chk("lock_c3_ar", l2_ar, AR0);
        l2_arready = 1'b1;
        #1; chk("lock_c4_ready", bank_arready, 2'b01);
        step();
        #1; chk("lock_next_ar", l2_ar, AR1);
        chk("lock_next_ready", bank_arready, 2'b10);
        step();
        bank_arvalid = 2'b00;

        // W ordering follows AW grant order, not W arrival order.
        do_reset();
        bank_awvalid = 2'b10; l2_awready = 1'b1;
        bank_wvalid = 2'b11; l2_wready = 1'b1;
        w1v = 73'h010; w0v = 73'h020;
        #1; chk("aw_p1_ready", bank_awready, 2'b10);
        chk("aw_p1_payload", l2_aw, AW1);
        chk("w_empty_valid", l2_wvalid, 1'b0);
        chk("w_empty_ready", bank_wready, 2'b00);
        step();
        bank_awvalid = 2'b01;
        for (int j = 0; j < 4; j++) begin
            w1v = (j == 3) ? 73'h113 : (73'h010 + 73'(j));
            #1;
            chk("w_p1_beat", l2_w, (j == 3) ? 73'h113 : (73'h010 + 73'(j)));
            chk("w_p1_ready", bank_wready, 2'b10);
            if (j == 0) chk("aw_p0_ready", bank_awready, 2'b01);
            step();
            if (j == 0) bank_awvalid = 2'b00;
        end
        for (int k = 0; k < 4; k++) begin
            w0v = (k == 3) ? 73'h123 : (73'h020 + 73'(k));
            #1;
            chk("w_p0_beat", l2_w, (k == 3) ? 73'h123 : (73'h020 + 73'(k)));
            chk("w_p0_ready", bank_wready, 2'b01);
            step();
        end
        #1; chk("w_drained", l2_wvalid, 1'b0);
        bank_wvalid = 2'b00;

        // B routing by index field (one write outstanding on each port).
        l2_bvalid = 1'b1; l2_b = 10'h045; bank_bready = 2'b10;
        #1; chk("b_valid_p1", bank_bvalid, 2'b10);
        chk("b_ready_p1", l2_bready, 1'b1);
        chk("b_broadcast", bank_b, {10'h045, 10'h045});
        step();
        l2_b = 10'h005; bank_bready = 2'b00;
        #1; chk("b_valid_p0", bank_bvalid, 2'b01);
        chk("b_ready_p0", l2_bready, 1'b0);
        l2_bvalid = 1'b0;

        // Outstanding-read limit and release by an rlast beat.
        do_reset();
        bank_arvalid = 2'b01; l2_arready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1; chk("outst_issue", bank_arready, 2'b01);
            step();
        end
        #1; chk("outst_blocked", l2_arvalid, 1'b0);
        chk("outst_blocked_rdy", bank_arready, 2'b00);
        l2_rvalid = 1'b1; l2_r = 78'h1; bank_rready = 2'b01;
        #1; chk("r_valid_p0", bank_rvalid, 2'b01);
        chk("r_ready_p0", l2_rready, 1'b1);
        chk("outst_still_blocked", l2_arvalid, 1'b0);
        step();
        l2_rvalid = 1'b0; bank_rready = 2'b00;
        #1; chk("outst_released", l2_arvalid, 1'b1);
        chk("outst_released_rdy", bank_arready, 2'b01);
        step();
        bank_arvalid = 2'b00;

        // Write-order FIFO full blocks AW until a wlast pops it.
        do_reset();
        bank_awvalid = 2'b11; l2_awready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1; chk("fifo_fill", bank_awready, (n % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        #1; chk("fifo_full_valid", l2_awvalid, 1'b0);
        chk("fifo_full_ready", bank_awready, 2'b00);
        bank_wvalid = 2'b01; w0v = 73'h100; l2_wready = 1'b1;
        #1; chk("fifo_pop_ready", bank_wready, 2'b01);
        chk("fifo_pop_aw_blocked", l2_awvalid, 1'b0);
        step();
        bank_wvalid = 2'b00;
        #1; chk("fifo_aw_resume", bank_awready, 2'b01);
        step();
        #1; chk("fifo_full_again", l2_awvalid, 1'b0);
        bank_awvalid = 2'b00;

        // Out-of-range R index is sunk and flagged.
        do_reset();
        l2_rvalid = 1'b1; l2_r = 78'd3 << 74; bank_rready = 2'b00;
        #1; chk("oor_rready", l2_rready, 1'b1);
        chk("oor_no_rvalid", bank_rvalid, 2'b00);
        chk("oor_err_before", resp_err, 1'b0);
        chk("r_broadcast", bank_r, {78'd3 << 74, 78'd3 << 74});
        step();
        l2_rvalid = 1'b0;
        #1; chk("oor_err_pulse", resp_err, 1'b1);
        step();
        chk("oor_err_clear", resp_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
